// File: rtl/sinc_engine_sched.sv
// sinc_engine_sched
// Round-robin scheduler that time-shares one sinc evaluation engine between
// NUM_CH requesters. Each job grants one requester, latches its angle, pulses
// the engine frame clear, holds the angle for ENG_LAT cycles, captures the
// engine result and returns it on a valid/ready port tagged with the channel.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_req_valid      per-channel request
//   i_req_theta      packed angles, channel c at [c*IN_WIDTH +: IN_WIDTH]
//   o_req_ready      one-hot grant, combinational, only while idle
//   o_eng_theta      angle held on the engine input
//   o_eng_clr_n      engine frame clear, active-low
//   i_eng_sinc       engine result
//   o_rsp_valid      response valid
//   i_rsp_ready      response accept
//   o_rsp_sinc       captured result
//   o_rsp_ch         channel of the response
//   i_abort          synchronous abort of an in-flight job
//   o_busy           scheduler not idle
//   o_done_cnt       accepted responses, wraps
module sinc_engine_sched #(
  parameter int NUM_CH   = 4,
  parameter int IN_WIDTH = 24,
  parameter int N_STAGES = 3,
  parameter int ENG_LAT  = (1 << N_STAGES) + 3,
  parameter int CH_W     = $clog2(NUM_CH),
  parameter int CNT_W    = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_CH-1:0]          i_req_valid,
  input  logic [NUM_CH*IN_WIDTH-1:0] i_req_theta,
  output logic [NUM_CH-1:0]          o_req_ready,
  output logic [IN_WIDTH-1:0]        o_eng_theta,
  output logic                       o_eng_clr_n,
  input  logic [IN_WIDTH-1:0]        i_eng_sinc,
  output logic                       o_rsp_valid,
  input  logic                       i_rsp_ready,
  output logic [IN_WIDTH-1:0]        o_rsp_sinc,
  output logic [CH_W-1:0]            o_rsp_ch,
  input  logic                       i_abort,
  output logic                       o_busy,
  output logic [CNT_W-1:0]           o_done_cnt
);

  localparam int CW = $clog2(ENG_LAT + 1);

  typedef enum logic [1:0] {IDLE, CLR, RUN, RESP} state_t;

  state_t               state_q, state_d;
  logic [CH_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IN_WIDTH-1:0]  theta_q, theta_d;
  logic [CH_W-1:0]      ch_q, ch_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 eng_clr_n_q, eng_clr_n_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 busy_q, busy_d;
  logic [IN_WIDTH-1:0]  rsp_sinc_q, rsp_sinc_d;
  logic [CH_W-1:0]      rsp_ch_q, rsp_ch_d;
  logic [CNT_W-1:0]     done_cnt_q, done_cnt_d;

  logic                 grant_found;
  logic [CH_W-1:0]      grant_idx;
  logic [CH_W:0]        scan_sum;
  logic                 grant_fire;
  logic [NUM_CH-1:0]    req_ready;
  logic [IN_WIDTH-1:0]  grant_theta;

  // Scan from the channel after the last grant, wrapping modulo NUM_CH.
  // The sum fits in CH_W+1 bits because both operands are below NUM_CH+1.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_sum    = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      scan_sum = {1'b0, rr_ptr_q} + (CH_W+1)'(i);
      if (scan_sum >= (CH_W+1)'(NUM_CH)) begin
        scan_sum = scan_sum - (CH_W+1)'(NUM_CH);
      end
      if (!grant_found && i_req_valid[scan_sum[CH_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_sum[CH_W-1:0];
      end
    end
  end

  // The grant is gated by reset so no handshake can complete while the
  // scheduler is held in reset.
  assign grant_fire  = i_rst_n && (state_q == IDLE) && grant_found && !i_abort;
  assign grant_theta = i_req_theta[grant_idx*IN_WIDTH +: IN_WIDTH];

  always_comb begin
    req_ready = '0;
    if (grant_fire) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Next-state logic. o_eng_clr_n is registered, so eng_clr_n_d is the value
  // for the following cycle: low when entering CLR or after an abort.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    theta_d     = theta_q;
    ch_d        = ch_q;
    cnt_d       = cnt_q;
    eng_clr_n_d = 1'b1;
    rsp_sinc_d  = rsp_sinc_q;
    rsp_ch_d    = rsp_ch_q;
    done_cnt_d  = done_cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_fire) begin
          theta_d     = grant_theta;
          ch_d        = grant_idx;
          rr_ptr_d    = grant_idx;
          eng_clr_n_d = 1'b0;
          state_d     = CLR;
        end
      end
      CLR: begin
        if (i_abort) begin
          eng_clr_n_d = 1'b0;
          state_d     = IDLE;
        end else begin
          cnt_d   = CW'(1);
          state_d = RUN;
        end
      end
      RUN: begin
        // Abort takes priority over the capture on the final cycle.
        if (i_abort) begin
          eng_clr_n_d = 1'b0;
          state_d     = IDLE;
        end else if (cnt_q == CW'(ENG_LAT)) begin
          rsp_sinc_d = i_eng_sinc;
          rsp_ch_d   = ch_q;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (i_rsp_ready) begin
          done_cnt_d = done_cnt_q + 1'b1;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    rsp_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= CH_W'(NUM_CH - 1);
      theta_q     <= '0;
      ch_q        <= '0;
      cnt_q       <= '0;
      eng_clr_n_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rsp_sinc_q  <= '0;
      rsp_ch_q    <= '0;
      done_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      theta_q     <= theta_d;
      ch_q        <= ch_d;
      cnt_q       <= cnt_d;
      eng_clr_n_q <= eng_clr_n_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      rsp_sinc_q  <= rsp_sinc_d;
      rsp_ch_q    <= rsp_ch_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  assign o_req_ready = req_ready;
  assign o_eng_theta = theta_q;
  assign o_eng_clr_n = eng_clr_n_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_sinc  = rsp_sinc_q;
  assign o_rsp_ch    = rsp_ch_q;
  assign o_busy      = busy_q;
  assign o_done_cnt  = done_cnt_q;

endmodule
